// File: rtl/chess_defs_pkg.sv
// Shared chess definitions: piece codes, colours, square address fields and the
// input-controller FSM encoding, common to the controller, display and board logic.
package chess_defs;

    localparam logic [2:0] PIECE_EMPTY  = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    // Square address: row in [5:3], column in [2:0].
    localparam int SQ_ROW_LSB = 3;
    localparam int SQ_COL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECTED = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    function automatic logic [2:0] sq_row(input logic [5:0] sq);
        return sq[SQ_ROW_LSB +: 3];
    endfunction

    function automatic logic [2:0] sq_col(input logic [5:0] sq);
        return sq[SQ_COL_LSB +: 3];
    endfunction

    function automatic logic [5:0] sq_make(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chess_input_controller_debouncer.sv
// One pushbutton: 2-flop synchroniser, stability counter and a single-cycle
// pulse on each accepted 0->1 transition of the stable level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                stable <= sync2;
                cnt    <= '0;
                pulse  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chess_input_controller.sv
// Cursor movement, piece selection and move-request generation for the board
// display; all outputs are registered.
module chess_input_controller
    import chess_defs::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [5:0] CURSOR_RESET    = 6'd0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_SEL,
    input  logic         BTN_CANCEL,
    input  logic [255:0] BOARD,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         MOVE_REQ,
    output logic [5:0]   MOVE_FROM,
    output logic [5:0]   MOVE_TO,
    input  logic         MOVE_ACK,
    input  logic         MOVE_OK,
    output logic         TURN,
    output state_t       DEBUG_STATE
);

    logic [5:0] btn_raw;
    logic [5:0] btn_pulse;

    assign btn_raw = {BTN_CANCEL, BTN_SEL, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
            .clk   (CLK),
            .rst_n (RESET),
            .btn   (btn_raw[i]),
            .pulse (btn_pulse[i])
        );
    end

    logic p_up, p_down, p_left, p_right, p_sel, p_cancel;
    assign {p_cancel, p_sel, p_right, p_left, p_down, p_up} = btn_pulse;

    state_t     state;
    logic [3:0] cur_piece;
    logic       cur_own;
    logic [2:0] row_nxt;
    logic [2:0] col_nxt;
    logic [5:0] cursor_nxt;

    assign cur_piece   = BOARD[{CURSOR_ADDR, 2'b00} +: 4];
    assign cur_own     = (cur_piece[2:0] != PIECE_EMPTY) && (cur_piece[3] == TURN);
    assign DEBUG_STATE = state;

    // Opposing directions on one axis cancel; each axis saturates at 0 and 7.
    always_comb begin
        row_nxt = sq_row(CURSOR_ADDR);
        col_nxt = sq_col(CURSOR_ADDR);
        if (p_up && !p_down && row_nxt != 3'd0)
            row_nxt = row_nxt - 3'd1;
        else if (p_down && !p_up && row_nxt != 3'd7)
            row_nxt = row_nxt + 3'd1;
        if (p_left && !p_right && col_nxt != 3'd0)
            col_nxt = col_nxt - 3'd1;
        else if (p_right && !p_left && col_nxt != 3'd7)
            col_nxt = col_nxt + 3'd1;
        cursor_nxt = sq_make(row_nxt, col_nxt);
    end

    // Move handshake: MOVE_REQ is a level that rises with MOVE_FROM/MOVE_TO valid and
    // holds them unchanged until MOVE_ACK is seen while MOVE_REQ is high; MOVE_OK is
    // only meaningful in that ack cycle, and MOVE_REQ drops on the following edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            CURSOR_ADDR <= CURSOR_RESET;
            SELECT_ADDR <= 6'd0;
            SELECT_EN   <= 1'b0;
            MOVE_REQ    <= 1'b0;
            MOVE_FROM   <= 6'd0;
            MOVE_TO     <= 6'd0;
            TURN        <= COLOR_WHITE;
        end else begin
            if (state != WAIT_ACK)
                CURSOR_ADDR <= cursor_nxt;
            case (state)
                IDLE: begin
                    if (!p_cancel && p_sel && cur_own) begin
                        SELECT_ADDR <= CURSOR_ADDR;
                        SELECT_EN   <= 1'b1;
                        state       <= SELECTED;
                    end
                end
                SELECTED: begin
                    if (p_cancel) begin
                        SELECT_EN <= 1'b0;
                        state     <= IDLE;
                    end else if (p_sel) begin
                        if (CURSOR_ADDR == SELECT_ADDR) begin
                            SELECT_EN <= 1'b0;
                            state     <= IDLE;
                        end else if (cur_own) begin
                            SELECT_ADDR <= CURSOR_ADDR;
                        end else begin
                            MOVE_FROM <= SELECT_ADDR;
                            MOVE_TO   <= CURSOR_ADDR;
                            MOVE_REQ  <= 1'b1;
                            state     <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (MOVE_REQ && MOVE_ACK) begin
                        MOVE_REQ <= 1'b0;
                        if (MOVE_OK) begin
                            SELECT_EN <= 1'b0;
                            TURN      <= ~TURN;
                            state     <= IDLE;
                        end else begin
                            state <= SELECTED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
